// File: rtl/router_egress.sv
// router_egress: four per-port FIFOs merged onto one ready/valid channel by round-robin.
// Optional per-port saturating drop counters when ROUTER_EGRESS_DROP_CNT_EN is defined.
module router_egress #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0][DATA_WIDTH-1:0] data_in,
  input  logic [3:0]                 valid_in,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [1:0]                 out_port,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 fifo_full
`ifdef ROUTER_EGRESS_DROP_CNT_EN
  ,
  output logic [3:0][7:0]            drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [4][FIFO_DEPTH];
  logic [AW-1:0]         r_wp  [4];
  logic [AW-1:0]         r_rp  [4];
  logic [CW-1:0]         r_cnt [4];

  logic [DATA_WIDTH-1:0] r_out_data;
  logic [1:0]            r_out_port;
  logic                  r_out_valid;
  logic [1:0]            r_rr_last;

  logic [3:0]            w_empty;
  logic [3:0]            w_full;
  logic [3:0]            w_push;
  logic [3:0]            w_pop;
  logic                  w_load;
  logic                  w_gnt_any;
  logic [1:0]            w_gnt_idx;
  logic [DATA_WIDTH-1:0] w_head;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_push  = '0;
    for (int i = 0; i < 4; i++) begin
      w_empty[i] = (r_cnt[i] == '0);
      w_full[i]  = (r_cnt[i] == FULL);
      // Room is judged on the pre-edge count; a same-cycle pop does not help.
      w_push[i]  = rst && valid_in[i] && !w_full[i];
    end
  end

  assign w_load = !r_out_valid || out_ready;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_rr_last;
    for (int k = 1; k < 5; k++) begin
      if (!w_gnt_any && !w_empty[2'(r_rr_last + 2'(k))]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = 2'(r_rr_last + 2'(k));
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_load && w_gnt_any) begin
      w_pop[w_gnt_idx] = 1'b1;
    end
  end

  assign w_head = r_mem[w_gnt_idx][r_rp[w_gnt_idx]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wp[i]] <= data_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) begin
          r_wp[i] <= r_wp[i] + AW'(1);
        end
        if (w_pop[i]) begin
          r_rp[i] <= r_rp[i] + AW'(1);
        end
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_out_valid <= 1'b0;
      r_rr_last   <= 2'd3;
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_out_data  <= w_head;
        r_out_port  <= w_gnt_idx;
        r_out_valid <= 1'b1;
        r_rr_last   <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ROUTER_EGRESS_DROP_CNT_EN
  logic [3:0][7:0] r_drop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (valid_in[i] && w_full[i] && r_drop[i] != 8'hFF) begin
          r_drop[i] <= r_drop[i] + 8'd1;
        end
      end
    end
  end

  assign drop_count = r_drop;
`endif

  assign out_data  = r_out_data;
  assign out_port  = r_out_port;
  assign out_valid = r_out_valid;
  assign fifo_full = w_full;

endmodule
